// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes, icodes, register ids and the W pipeline register layout.
package y86_pkg;

    localparam int Y86_DATA_W = 64;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef struct packed {
        logic [2:0]            stat;
        logic [3:0]            icode;
        logic [Y86_DATA_W-1:0] valE;
        logic [Y86_DATA_W-1:0] valM;
        logic [3:0]            dstE;
        logic [3:0]            dstM;
    } w_reg_t;

    localparam w_reg_t W_BUBBLE = '{stat: STAT_AOK, icode: I_NOP, valE: '0, valM: '0,
                                    dstE: RNONE, dstM: RNONE};

    // Codes 0 and 5..7 are deliberately not faults; only the three architected ones stop the machine.
    function automatic logic is_fault(input logic [2:0] s);
        return (s == STAT_HLT) || (s == STAT_ADR) || (s == STAT_INS);
    endfunction

endpackage

// File: rtl/y86_wb_status.sv
// RUN/HALTED status tracker and retired-instruction counter for the write-back stage.
// Halts on the same edge a faulting instruction enters W, so halted/stat line up with that instruction.
module y86_wb_status
    import y86_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [2:0]       m_stat,
    input  logic [3:0]       m_icode,
    input  logic [2:0]       w_stat_nxt,
    output logic             halted,
    output logic [2:0]       stat,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    state_t           state_q, state_d;
    logic [2:0]       code_q, code_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        retired_d = retired_q;
        case (state_q)
            ST_RUN: begin
                if (load_en && (m_icode != I_NOP) && (m_stat == STAT_AOK))
                    retired_d = retired_q + CNT_W'(1);
                if (is_fault(w_stat_nxt)) begin
                    state_d = ST_HALTED;
                    code_d  = w_stat_nxt;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            code_q    <= STAT_AOK;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            retired_q <= retired_d;
        end
    end

    assign halted  = (state_q == ST_HALTED);
    assign stat    = halted ? code_q : STAT_AOK;
    assign retired = retired_q;

endmodule

// File: rtl/y86_writeback_stage.sv
// Y86-64 write-back stage: W pipeline register, register-file write-port drive and forwarding values.
// One cycle m_* -> w_*; stall holds W, bubble (which beats stall) inserts a nop, halt freezes W for good.
module y86_writeback_stage
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        m_stat,
    input  logic [3:0]        m_icode,
    input  logic [DATA_W-1:0] m_valE,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [3:0]        m_dstE,
    input  logic [3:0]        m_dstM,
    input  logic              W_stall,
    input  logic              W_bubble,
    output logic [3:0]        w_dstE,
    output logic [DATA_W-1:0] w_valE,
    output logic [3:0]        w_dstM,
    output logic [DATA_W-1:0] w_valM,
    output logic [3:0]        W_icode,
    output logic [2:0]        stat,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    w_reg_t w_q, w_d;
    logic   load_en;
    logic   wr_kill;
    logic   collide;

    assign load_en = !halted && !W_bubble && !W_stall;

    always_comb begin
        w_d = w_q;
        if (!halted) begin
            if (W_bubble) begin
                w_d = W_BUBBLE;
            end else if (!W_stall) begin
                w_d.stat  = m_stat;
                w_d.icode = m_icode;
                w_d.valE  = Y86_DATA_W'(m_valE);
                w_d.valM  = Y86_DATA_W'(m_valM);
                w_d.dstE  = m_dstE;
                w_d.dstM  = m_dstM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_q <= W_BUBBLE;
        else        w_q <= w_d;
    end

    y86_wb_status #(.CNT_W(CNT_W)) u_status (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (load_en),
        .m_stat     (m_stat),
        .m_icode    (m_icode),
        .w_stat_nxt (w_d.stat),
        .halted     (halted),
        .stat       (stat),
        .retired    (retired)
    );

    // popq %rsp loads both ports with %rsp; the memory value must be the one that sticks.
    assign collide = (w_q.dstE == w_q.dstM) && (w_q.dstM != RNONE);
    assign wr_kill = (w_q.stat != STAT_AOK) || halted;

    assign w_dstE  = (wr_kill || collide) ? RNONE : w_q.dstE;
    assign w_dstM  = wr_kill ? RNONE : w_q.dstM;
    assign w_valE  = DATA_W'(w_q.valE);
    assign w_valM  = DATA_W'(w_q.valM);
    assign W_icode = w_q.icode;

endmodule

// File: tb/tb_y86_writeback_stage.sv
// Bench for y86_writeback_stage: directed scenarios plus randomized traffic against a reference model.
module tb_y86_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  m_stat = 3'd1;
    logic [3:0]  m_icode = 4'h1;
    logic [63:0] m_valE = '0;
    logic [63:0] m_valM = '0;
    logic [3:0]  m_dstE = 4'hF;
    logic [3:0]  m_dstM = 4'hF;
    logic        W_stall = 1'b0;
    logic        W_bubble = 1'b0;
    logic [3:0]  w_dstE, w_dstM, W_icode;
    logic [63:0] w_valE, w_valM;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] retired;

    int n_checks = 0;
    int n_fail = 0;

    // Reference state: the instruction sitting in W plus machine status.
    logic [2:0]  r_stat;
    logic [3:0]  r_icode, r_dstE, r_dstM;
    logic [63:0] r_valE, r_valM;
    logic        r_halted;
    logic [2:0]  r_code;
    logic [31:0] r_retired;

    y86_writeback_stage dut (
        .clk(clk), .rst_n(rst_n), .m_stat(m_stat), .m_icode(m_icode),
        .m_valE(m_valE), .m_valM(m_valM), .m_dstE(m_dstE), .m_dstM(m_dstM),
        .W_stall(W_stall), .W_bubble(W_bubble), .w_dstE(w_dstE), .w_valE(w_valE),
        .w_dstM(w_dstM), .w_valM(w_valM), .W_icode(W_icode), .stat(stat),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        r_stat = 3'd1; r_icode = 4'h1; r_dstE = 4'hF; r_dstM = 4'hF;
        r_valE = '0; r_valM = '0; r_halted = 1'b0; r_code = 3'd1; r_retired = '0;
    endtask

    task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] ve,
                         input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm,
                         input logic stl, input logic bub);
        m_stat = st; m_icode = ic; m_valE = ve; m_valM = vm;
        m_dstE = de; m_dstM = dm; W_stall = stl; W_bubble = bub;
    endtask

    // Advance one clock, updating the model from the inputs currently applied.
    task automatic tick();
        if (!r_halted) begin
            if (W_bubble) begin
                r_stat = 3'd1; r_icode = 4'h1; r_dstE = 4'hF; r_dstM = 4'hF; r_valE = '0; r_valM = '0;
            end else if (!W_stall) begin
                r_stat = m_stat; r_icode = m_icode; r_dstE = m_dstE; r_dstM = m_dstM;
                r_valE = m_valE; r_valM = m_valM;
                if (m_icode != 4'h1 && m_stat == 3'd1) r_retired = r_retired + 1;
            end
            if (r_stat >= 3'd2 && r_stat <= 3'd4) begin
                r_halted = 1'b1;
                r_code = r_stat;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_dstE();
        if (r_halted || r_stat != 3'd1) return 4'hF;
        if (r_dstE == r_dstM && r_dstM != 4'hF) return 4'hF;
        return r_dstE;
    endfunction

    function automatic logic [3:0] exp_dstM();
        if (r_halted || r_stat != 3'd1) return 4'hF;
        return r_dstM;
    endfunction

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        drive(3'd1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b0);
        #12;
        rst_n = 1'b1;
        tick();
        n_checks++; if (w_dstE !== 4'hF) begin n_fail++; $display("FAIL reset_dstE got %h want f", w_dstE); end
        n_checks++; if (w_dstM !== 4'hF) begin n_fail++; $display("FAIL reset_dstM got %h want f", w_dstM); end
        n_checks++; if (stat !== 3'd1) begin n_fail++; $display("FAIL reset_stat got %0d want 1", stat); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
        n_checks++; if (retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired got %0d want 0", retired); end
    endtask

    task automatic test_irmovq();
        drive(3'd1, 4'h3, 64'h1234, 64'h0, 4'd3, 4'hF, 1'b0, 1'b0);
        tick();
        n_checks++; if (w_dstE !== 4'd3) begin n_fail++; $display("FAIL irmovq_dstE got %h want 3", w_dstE); end
        n_checks++; if (w_valE !== 64'h1234) begin n_fail++; $display("FAIL irmovq_valE got %h want 1234", w_valE); end
        n_checks++; if (retired !== 32'd1) begin n_fail++; $display("FAIL irmovq_retired got %0d want 1", retired); end
    endtask

    task automatic test_popq_rsp();
        drive(3'd1, 4'hB, 64'h108, 64'hABC, 4'd4, 4'd4, 1'b0, 1'b0);
        tick();
        n_checks++; if (w_dstE !== 4'hF) begin n_fail++; $display("FAIL popq_dstE got %h want f", w_dstE); end
        n_checks++; if (w_dstM !== 4'd4) begin n_fail++; $display("FAIL popq_dstM got %h want 4", w_dstM); end
        n_checks++; if (w_valM !== 64'hABC) begin n_fail++; $display("FAIL popq_valM got %h want abc", w_valM); end
        n_checks++; if (retired !== 32'd2) begin n_fail++; $display("FAIL popq_retired got %0d want 2", retired); end
    endtask

    task automatic test_stall_bubble();
        drive(3'd1, 4'h6, 64'h77, 64'h55, 4'd1, 4'd2, 1'b1, 1'b0);
        tick();
        tick();
        n_checks++; if (w_dstM !== 4'd4) begin n_fail++; $display("FAIL stall_dstM got %h want 4", w_dstM); end
        n_checks++; if (w_valM !== 64'hABC) begin n_fail++; $display("FAIL stall_valM got %h want abc", w_valM); end
        n_checks++; if (W_icode !== 4'hB) begin n_fail++; $display("FAIL stall_icode got %h want b", W_icode); end
        n_checks++; if (retired !== 32'd2) begin n_fail++; $display("FAIL stall_retired got %0d want 2", retired); end
        drive(3'd1, 4'h6, 64'h77, 64'h55, 4'd1, 4'd2, 1'b1, 1'b1);
        tick();
        n_checks++; if (W_icode !== 4'h1) begin n_fail++; $display("FAIL bubble_icode got %h want 1", W_icode); end
        n_checks++; if (w_dstM !== 4'hF) begin n_fail++; $display("FAIL bubble_dstM got %h want f", w_dstM); end
        n_checks++; if (retired !== 32'd2) begin n_fail++; $display("FAIL bubble_retired got %0d want 2", retired); end
    endtask

    task automatic test_halt();
        drive(3'd1, 4'h3, 64'h9, 64'h0, 4'd7, 4'hF, 1'b0, 1'b0);
        tick();
        drive(3'd5, 4'h3, 64'h9, 64'h0, 4'd6, 4'hF, 1'b0, 1'b0);
        tick();
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL stat5_halted got %b want 0", halted); end
        n_checks++; if (stat !== 3'd1) begin n_fail++; $display("FAIL stat5_stat got %0d want 1", stat); end
        drive(3'd2, 4'h0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b0);
        tick();
        n_checks++; if (stat !== 3'd2) begin n_fail++; $display("FAIL halt_stat got %0d want 2", stat); end
        n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_halted got %b want 1", halted); end
        n_checks++; if (retired !== 32'd3) begin n_fail++; $display("FAIL halt_retired got %0d want 3", retired); end
        drive(3'd1, 4'h3, 64'h55, 64'h0, 4'd5, 4'hF, 1'b0, 1'b0);
        tick();
        tick();
        n_checks++; if (w_dstE !== 4'hF) begin n_fail++; $display("FAIL halt_masked_dstE got %h want f", w_dstE); end
        n_checks++; if (w_dstM !== 4'hF) begin n_fail++; $display("FAIL halt_masked_dstM got %h want f", w_dstM); end
        n_checks++; if (W_icode !== 4'h0) begin n_fail++; $display("FAIL halt_frozen_icode got %h want 0", W_icode); end
        n_checks++; if (retired !== 32'd3) begin n_fail++; $display("FAIL halt_frozen_retired got %0d want 3", retired); end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        drive(3'd1, 4'h2, 64'h42, 64'h0, 4'd2, 4'hF, 1'b0, 1'b0);
        tick();
        n_checks++; if (w_dstE !== 4'd2) begin n_fail++; $display("FAIL midrst_pre_dstE got %h want 2", w_dstE); end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (w_dstE !== 4'hF) begin n_fail++; $display("FAIL midrst_dstE got %h want f", w_dstE); end
        n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL midrst_halted got %b want 0", halted); end
        n_checks++; if (retired !== 32'd0) begin n_fail++; $display("FAIL midrst_retired got %0d want 0", retired); end
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int halt_age = 0;
        for (int i = 0; i < 600; i++) begin
            logic [2:0] st;
            logic [3:0] de, dm;
            st = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            de = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            dm = ($urandom_range(0, 2) == 0) ? de : (($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 14)));
            drive(st, 4'($urandom_range(0, 11)), {$urandom, $urandom}, {$urandom, $urandom}, de, dm,
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
            tick();
            n_checks++; if (w_dstE !== exp_dstE()) begin n_fail++; $display("FAIL rnd_dstE cyc %0d got %h want %h", i, w_dstE, exp_dstE()); end
            n_checks++; if (w_dstM !== exp_dstM()) begin n_fail++; $display("FAIL rnd_dstM cyc %0d got %h want %h", i, w_dstM, exp_dstM()); end
            n_checks++; if (w_valE !== r_valE) begin n_fail++; $display("FAIL rnd_valE cyc %0d got %h want %h", i, w_valE, r_valE); end
            n_checks++; if (w_valM !== r_valM) begin n_fail++; $display("FAIL rnd_valM cyc %0d got %h want %h", i, w_valM, r_valM); end
            n_checks++; if (W_icode !== r_icode) begin n_fail++; $display("FAIL rnd_icode cyc %0d got %h want %h", i, W_icode, r_icode); end
            n_checks++; if (stat !== (r_halted ? r_code : 3'd1)) begin n_fail++; $display("FAIL rnd_stat cyc %0d got %0d want %0d", i, stat, r_halted ? r_code : 3'd1); end
            n_checks++; if (halted !== r_halted) begin n_fail++; $display("FAIL rnd_halted cyc %0d got %b want %b", i, halted, r_halted); end
            n_checks++; if (retired !== r_retired) begin n_fail++; $display("FAIL rnd_retired cyc %0d got %0d want %0d", i, retired, r_retired); end
            if (r_halted) halt_age++;
            if (halt_age > 4) begin
                pulse_reset();
                halt_age = 0;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_irmovq();
        test_popq_rsp();
        test_stall_bubble();
        test_halt();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
